// File: rtl/usr_pkg.sv
// Shared types for the universal shift register: command opcodes, FSM
// states and the shift-amount width helper.
package usr_pkg;

  typedef enum logic [2:0] {
    OP_HOLD  = 3'b000,
    OP_LOAD  = 3'b001,
    OP_SHL   = 3'b010,
    OP_SHR   = 3'b011,
    OP_ROL   = 3'b100,
    OP_ROR   = 3'b101,
    OP_ASR   = 3'b110,
    OP_CLEAR = 3'b111
  } usr_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } usr_state_e;

  // Bits needed to hold a shift amount in the range 0..width inclusive.
  function automatic int usr_cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/usr_step.sv
// Combinational single-step shifter: applies one bit of the selected
// shift/rotate op and reports the bit that leaves the register.
module usr_step
  import usr_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  usr_op_e          op,
  input  logic [WIDTH-1:0] q,
  input  logic             ser_in,
  output logic [WIDTH-1:0] next_q,
  output logic             out_bit
);

  // One-bit step for each shift-class op; anything else passes q through.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    next_q  = q;
    out_bit = 1'b0;
    case (op)
      OP_SHL: begin next_q = {q[WIDTH-2:0], ser_in};   out_bit = q[WIDTH-1]; end
      OP_SHR: begin next_q = {ser_in, q[WIDTH-1:1]};   out_bit = q[0];       end
      OP_ROL: begin next_q = {q[WIDTH-2:0], q[WIDTH-1]}; out_bit = q[WIDTH-1]; end
      OP_ROR: begin next_q = {q[0], q[WIDTH-1:1]};     out_bit = q[0];       end
      OP_ASR: begin next_q = {q[WIDTH-1], q[WIDTH-1:1]}; out_bit = q[0];     end
      default: ;
    endcase
  end

endmodule

// File: rtl/univ_shift_reg_seq.sv
// Universal shift register with a valid/ready command interface.
// Multi-bit shifts run one bit per clock under an IDLE/RUN FSM.
// Build option: define USR_BARREL_EN to finish every shift in the
// acceptance cycle through a barrel path (busy then stays low).
module univ_shift_reg_seq
  import usr_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CNT_W = usr_cnt_w(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_amt,
  input  logic [WIDTH-1:0] load_data,
  input  logic             ser_in,
  output logic [WIDTH-1:0] q,
  output logic             ser_out,
  output logic             busy,
  output logic             done
);

  usr_state_e       state_q, state_d;
  usr_op_e          op_q, op_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             ser_out_q, ser_out_d;
  logic             done_q, done_d;

  usr_op_e          acc_op;
  logic [CNT_W-1:0] amt_c;
  logic             accept;

  // Decode the incoming command and clamp its amount to the register width.
  always_comb begin
    acc_op = usr_op_e'(cmd_op);
    amt_c  = (cmd_amt > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : cmd_amt;
    accept = cmd_valid && cmd_ready;
  end

`ifdef USR_BARREL_EN
  logic [WIDTH-1:0] barrel_q, left_tap, right_tap;
  logic             barrel_out;

  // Full multi-bit shift in one cycle; taps pick the last bit to leave.
  always_comb begin
    left_tap   = q_q >> (CNT_W'(WIDTH) - amt_c);
    right_tap  = q_q >> (amt_c - CNT_W'(1));
    barrel_q   = q_q;
    barrel_out = 1'b0;
    case (acc_op)
      OP_SHL: begin
        barrel_q   = (q_q << amt_c) | (ser_in ? ~({WIDTH{1'b1}} << amt_c) : '0);
        barrel_out = left_tap[0];
      end
      OP_SHR: begin
        barrel_q   = (q_q >> amt_c) | (ser_in ? ~({WIDTH{1'b1}} >> amt_c) : '0);
        barrel_out = right_tap[0];
      end
      OP_ROL: begin
        barrel_q   = (q_q << amt_c) | (q_q >> (CNT_W'(WIDTH) - amt_c));
        barrel_out = left_tap[0];
      end
      OP_ROR: begin
        barrel_q   = (q_q >> amt_c) | (q_q << (CNT_W'(WIDTH) - amt_c));
        barrel_out = right_tap[0];
      end
      OP_ASR: begin
        barrel_q   = WIDTH'($signed(q_q) >>> amt_c);
        barrel_out = right_tap[0];
      end
      default: ;
    endcase
  end
`else
  usr_op_e          step_op;
  logic [WIDTH-1:0] step_q;
  logic             step_out;

  // The first step uses the op being accepted; later steps the latched op.
  always_comb step_op = (state_q == ST_RUN) ? op_q : acc_op;

  usr_step #(.WIDTH(WIDTH)) u_step (
    .op      (step_op),
    .q       (q_q),
    .ser_in  (ser_in),
    .next_q  (step_q),
    .out_bit (step_out)
  );
`endif

  // Next-state, datapath update and done generation.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    rem_d     = rem_q;
    q_d       = q_q;
    ser_out_d = ser_out_q;
    done_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          done_d = 1'b1;
          case (acc_op)
            OP_HOLD:  ;
            OP_LOAD:  q_d = load_data;
            OP_CLEAR: begin
              q_d       = '0;
              ser_out_d = 1'b0;
            end
            default: begin
              if (amt_c != '0) begin
`ifdef USR_BARREL_EN
                q_d       = barrel_q;
                ser_out_d = barrel_out;
`else
                q_d       = step_q;
                ser_out_d = step_out;
                if (amt_c != CNT_W'(1)) begin
                  state_d = ST_RUN;
                  op_d    = acc_op;
                  rem_d   = amt_c - CNT_W'(1);
                  done_d  = 1'b0;
                end
`endif
              end
            end
          endcase
        end
      end
`ifndef USR_BARREL_EN
      ST_RUN: begin
        q_d       = step_q;
        ser_out_d = step_out;
        rem_d     = rem_q - CNT_W'(1);
        if (rem_q == CNT_W'(1)) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      state_q   <= ST_IDLE;
      op_q      <= OP_HOLD;
      rem_q     <= '0;
      q_q       <= '0;
      ser_out_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      rem_q     <= rem_d;
      q_q       <= q_d;
      ser_out_q <= ser_out_d;
      done_q    <= done_d;
    end
  end

  assign cmd_ready = (state_q == ST_IDLE) && !reset;
  assign q         = q_q;
  assign ser_out   = ser_out_q;
  assign done      = done_q;
`ifdef USR_BARREL_EN
  assign busy      = 1'b0;
`else
  assign busy      = (state_q == ST_RUN);
`endif

endmodule
